// File: rtl/l1a_pkg.sv
// Shared constants and helpers for the L1A trigger capture front end.
// Used by the per-channel capture slice, the top level and anything that unpacks l1a_bus.
package l1a_pkg;

    localparam int NCH   = 16;
    localparam int CNT_W = 14;
    localparam int CH_W  = 4;

    // Extract one channel's latched L1A number from the flat bus.
    function automatic logic [CNT_W-1:0] l1a_slice(input logic [NCH*CNT_W-1:0] bus,
                                                   input logic [CH_W-1:0]      ch);
        return bus[ch*CNT_W +: CNT_W];
    endfunction

endpackage

// File: rtl/l1a_chan_capture.sv
// One ADC channel: synchronises its trigger, counts L1As and holds the
// latched value plus pending/overrun/seen state until the checker acks it.
module l1a_chan_capture
    import l1a_pkg::*;
#(
    parameter int CNT_W       = l1a_pkg::CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_raw,
    input  logic             arm,
    input  logic             ack,
    output logic [CNT_W-1:0] latch,
    output logic             pend,
    output logic             overrun,
    output logic             start_check
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   delay;
    logic                   seen;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   trig_edge;
    logic                   pend_after_ack;

    assign trig_edge      = sync[SYNC_STAGES-1] & ~delay;
    assign cnt_next       = cnt + CNT_W'(1);
    // An ack in the same cycle frees the slot before the new edge is considered.
    assign pend_after_ack = pend & ~ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= '0;
            delay       <= 1'b0;
            seen        <= 1'b0;
            cnt         <= '0;
            latch       <= '0;
            pend        <= 1'b0;
            overrun     <= 1'b0;
            start_check <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], trig_raw};
            delay       <= sync[SYNC_STAGES-1];
            seen        <= arm & (seen | trig_edge);
            start_check <= arm & seen;

            if (trig_edge) begin
                cnt  <= cnt_next;
                pend <= 1'b1;
                if (!pend_after_ack) begin
                    latch <= cnt_next;
                end else begin
                    overrun <= 1'b1;
                end
            end else begin
                pend <= pend_after_ack;
            end
        end
    end

endmodule

// File: rtl/l1a_trigger_capture.sv
// L1A trigger capture top: NCH capture slices, the checker's round-robin
// acknowledge pointer, and a watchdog that flags a checker that stops acking.
module l1a_trigger_capture
    import l1a_pkg::*;
#(
    parameter int NCH         = l1a_pkg::NCH,
    parameter int CNT_W       = l1a_pkg::CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int STALL_CYC   = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       trig_raw,
    input  logic                 arm,
    input  logic                 cnt_clear,
    input  logic                 finish_ack,
    output logic [NCH*CNT_W-1:0] l1a_bus,
    output logic [NCH-1:0]       trig_pend,
    output logic [NCH-1:0]       start_check,
    output logic [CH_W-1:0]      ack_ptr,
    output logic [NCH-1:0]       overrun,
    output logic                 stall
);

    localparam int            SW        = $clog2(STALL_CYC);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYC - 1);

    logic           clear;
    logic [NCH-1:0] ack_vec;
    logic [SW-1:0]  stall_cnt;

    assign clear   = reset | cnt_clear;
    assign ack_vec = finish_ack ? (NCH'(1) << ack_ptr) : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        l1a_chan_capture #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk        (clk),
            .reset      (clear),
            .trig_raw   (trig_raw[i]),
            .arm        (arm),
            .ack        (ack_vec[i]),
            .latch      (l1a_bus[i*CNT_W +: CNT_W]),
            .pend       (trig_pend[i]),
            .overrun    (overrun[i]),
            .start_check(start_check[i])
        );
    end

    // The pointer advances on every ack, even for a channel with nothing pending.
    always_ff @(posedge clk) begin
        if (clear) begin
            ack_ptr <= '0;
        end else if (finish_ack) begin
            ack_ptr <= (ack_ptr == CH_W'(NCH - 1)) ? '0 : ack_ptr + CH_W'(1);
        end
    end

    // Watchdog counts cycles of outstanding work without progress; it saturates.
    always_ff @(posedge clk) begin
        if (clear) begin
            stall_cnt <= '0;
            stall     <= 1'b0;
        end else if (finish_ack || !(|trig_pend)) begin
            stall_cnt <= '0;
        end else if (stall_cnt == STALL_MAX) begin
            stall <= 1'b1;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_l1a_trigger_capture.sv
// Directed self-checking bench for l1a_trigger_capture (watchdog shortened to 16 cycles).
module tb_l1a_trigger_capture;
    import l1a_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       trig_raw;
    logic                 arm;
    logic                 cnt_clear;
    logic                 finish_ack;
    logic [NCH*CNT_W-1:0] l1a_bus;
    logic [NCH-1:0]       trig_pend;
    logic [NCH-1:0]       start_check;
    logic [CH_W-1:0]      ack_ptr;
    logic [NCH-1:0]       overrun;
    logic                 stall;

    int checks   = 0;
    int failures = 0;

    l1a_trigger_capture #(
        .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(2), .STALL_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .trig_raw(trig_raw), .arm(arm),
        .cnt_clear(cnt_clear), .finish_ack(finish_ack), .l1a_bus(l1a_bus),
        .trig_pend(trig_pend), .start_check(start_check), .ack_ptr(ack_ptr),
        .overrun(overrun), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw high for two samples, low for one; state is visible on return.
    task automatic pulse(input logic [NCH-1:0] mask);
        trig_raw = mask;
        step(2);
        trig_raw = '0;
        step(1);
    endtask

    task automatic ack_n(input int n);
        for (int i = 0; i < n; i++) begin
            finish_ack = 1'b1;
            step(1);
            finish_ack = 1'b0;
        end
    endtask

    task automatic do_clear();
        cnt_clear = 1'b1;
        step(1);
        cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; trig_raw = '0; arm = 1'b0; cnt_clear = 1'b0; finish_ack = 1'b0;
        step(2);
        reset = 1'b0;
        checks++;
        if (l1a_bus !== '0 || trig_pend !== '0 || start_check !== '0 ||
            ack_ptr !== '0 || overrun !== '0 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: pend=%h start=%h ptr=%0d ovr=%h stall=%b bus_nonzero=%b required all zero",
                     trig_pend, start_check, ack_ptr, overrun, stall, |l1a_bus);
        end
    endtask

    task automatic test_first_trigger();
        trig_raw = 16'h0001;
        step(2);
        trig_raw = '0;
        checks++;
        if (trig_pend !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL latency_early: pend=%h required 0000", trig_pend);
        end
        step(1);
        checks++;
        if (trig_pend !== 16'h0001 || l1a_slice(l1a_bus, 4'd0) !== 14'd1) begin
            failures++;
            $display("[TB] FAIL first_trigger: pend=%h latch0=%0d required pend=0001 latch0=1",
                     trig_pend, l1a_slice(l1a_bus, 4'd0));
        end
        checks++;
        if ((l1a_bus >> CNT_W) !== '0 || ack_ptr !== 4'd0 || overrun !== '0) begin
            failures++;
            $display("[TB] FAIL first_others: ptr=%0d ovr=%h upper_nonzero=%b required 0",
                     ack_ptr, overrun, |(l1a_bus >> CNT_W));
        end
    endtask

    task automatic test_all_channels();
        logic [NCH-1:0] exp_pend;
        do_clear();
        arm = 1'b1;
        step(1);
        pulse('1);
        step(1);
        checks++;
        if (start_check !== 16'hFFFF || trig_pend !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL all_start: start=%h pend=%h required FFFF FFFF", start_check, trig_pend);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (l1a_slice(l1a_bus, 4'(c)) !== 14'd1) begin
                failures++;
                $display("[TB] FAIL all_latch ch%0d: got %0d required 1", c, l1a_slice(l1a_bus, 4'(c)));
            end
        end
        exp_pend = 16'hFFFF;
        for (int c = 0; c < NCH; c++) begin
            ack_n(1);
            exp_pend[c] = 1'b0;
            checks++;
            if (trig_pend !== exp_pend || ack_ptr !== 4'((c + 1) % NCH)) begin
                failures++;
                $display("[TB] FAIL ack_order %0d: pend=%h ptr=%0d required pend=%h ptr=%0d",
                         c, trig_pend, ack_ptr, exp_pend, (c + 1) % NCH);
            end
            step(2);
        end
        arm = 1'b0;
        step(1);
        checks++;
        if (start_check !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL disarm: start=%h required 0000", start_check);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        for (int n = 0; n < 16383; n++) pulse(16'h0020);
        checks++;
        if (l1a_slice(l1a_bus, 4'd5) !== 14'd1 || trig_pend !== 16'h0020) begin
            failures++;
            $display("[TB] FAIL preload_hold: latch5=%0d pend=%h required 1 0020",
                     l1a_slice(l1a_bus, 4'd5), trig_pend);
        end
        ack_n(6);
        checks++;
        if (trig_pend !== 16'h0000 || ack_ptr !== 4'd6) begin
            failures++;
            $display("[TB] FAIL wrap_ack: pend=%h ptr=%0d required 0000 6", trig_pend, ack_ptr);
        end
        pulse(16'h0020);
        checks++;
        if (l1a_slice(l1a_bus, 4'd5) !== 14'd0 || trig_pend !== 16'h0020 || (overrun & ~16'h0020) !== '0) begin
            failures++;
            $display("[TB] FAIL wrap: latch5=%0d pend=%h ovr=%h required 0 0020 others 0",
                     l1a_slice(l1a_bus, 4'd5), trig_pend, overrun);
        end
    endtask

    task automatic test_overrun();
        do_clear();
        pulse(16'h0008);
        pulse(16'h0008);
        checks++;
        if (overrun !== 16'h0008 || l1a_slice(l1a_bus, 4'd3) !== 14'd1 || trig_pend !== 16'h0008) begin
            failures++;
            $display("[TB] FAIL overrun: ovr=%h latch3=%0d pend=%h required 0008 1 0008",
                     overrun, l1a_slice(l1a_bus, 4'd3), trig_pend);
        end
        ack_n(4);
        checks++;
        if (trig_pend !== 16'h0000 || ack_ptr !== 4'd4) begin
            failures++;
            $display("[TB] FAIL overrun_ack: pend=%h ptr=%0d required 0000 4", trig_pend, ack_ptr);
        end
        pulse(16'h0008);
        checks++;
        if (l1a_slice(l1a_bus, 4'd3) !== 14'd3 || trig_pend !== 16'h0008) begin
            failures++;
            $display("[TB] FAIL overrun_next: latch3=%0d pend=%h required 3 0008",
                     l1a_slice(l1a_bus, 4'd3), trig_pend);
        end
    endtask

    task automatic test_same_cycle();
        do_clear();
        pulse(16'h0004);
        ack_n(2);
        trig_raw = 16'h0004;
        step(2);
        trig_raw   = '0;
        finish_ack = 1'b1;
        step(1);
        finish_ack = 1'b0;
        checks++;
        if (trig_pend !== 16'h0004 || l1a_slice(l1a_bus, 4'd2) !== 14'd2 ||
            overrun !== 16'h0000 || ack_ptr !== 4'd3) begin
            failures++;
            $display("[TB] FAIL same_cycle: pend=%h latch2=%0d ovr=%h ptr=%0d required 0004 2 0000 3",
                     trig_pend, l1a_slice(l1a_bus, 4'd2), overrun, ack_ptr);
        end
    endtask

    task automatic test_stall_and_clear();
        do_clear();
        pulse(16'h0001);
        step(15);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_early: stall=%b required 0", stall);
        end
        step(1);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_set: stall=%b required 1", stall);
        end
        arm = 1'b1;
        pulse(16'h0102);
        step(2);
        do_clear();
        arm = 1'b0;
        checks++;
        if (l1a_bus !== '0 || trig_pend !== '0 || start_check !== '0 ||
            ack_ptr !== '0 || overrun !== '0 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_clear: pend=%h start=%h ptr=%0d ovr=%h stall=%b bus_nonzero=%b required all zero",
                     trig_pend, start_check, ack_ptr, overrun, stall, |l1a_bus);
        end
    endtask

    initial begin
        test_reset();
        test_first_trigger();
        test_all_channels();
        test_overrun();
        test_same_cycle();
        test_wrap();
        test_stall_and_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
